// File: rtl/scratch_mem_arbiter_pkg.sv
// Shared constants and types for the scratch memory arbiter: memory geometry,
// requester slot assignments and the arbiter state encoding.
package scratch_mem_arbiter_pkg;

    localparam int SCRATCH_ADDR_W = 11;
    localparam int SCRATCH_DATA_W = 32;

    localparam int REQ_PERC_VAR = 0;
    localparam int REQ_INTERP   = 1;
    localparam int REQ_LEV_DUR  = 2;
    localparam int REQ_LSP_QUA  = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

    // Successor of idx in a ring of n slots.
    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/scratch_mem_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first requester with req high
// scanning start, start+1, ... wrapping modulo NUM_REQ.
module scratch_mem_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    always_comb begin
        int              cand;
        logic [IDX_W-1:0] cand_idx;
        cand     = 0;
        cand_idx = '0;
        idx      = '0;
        valid    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(start) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!valid && req[cand_idx]) begin
                valid = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/scratch_mem_arbiter.sv
// Round-robin owner of the single-port scratch memory: grants whole bursts,
// muxes the owner's address/write lines, and lets the test port override all.
module scratch_mem_arbiter
    import scratch_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 4096
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 req,
    input  logic [NUM_REQ-1:0]                 reqWE,
    input  logic [NUM_REQ*SCRATCH_ADDR_W-1:0]  reqAddr,
    input  logic [NUM_REQ*SCRATCH_DATA_W-1:0]  reqData,
    output logic [NUM_REQ-1:0]                 grant,
    input  logic                               testMuxSel,
    input  logic                               testMemWrite,
    input  logic [SCRATCH_ADDR_W-1:0]          testWriteAddr,
    input  logic [SCRATCH_ADDR_W-1:0]          testReadAddr,
    input  logic [SCRATCH_DATA_W-1:0]          testMemOut,
    output logic [SCRATCH_ADDR_W-1:0]          memAddr,
    output logic                               memWE,
    output logic [SCRATCH_DATA_W-1:0]          memOut,
    output logic                               holdViolation,
    output arb_state_e                         dbg_state
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD);

    // Handshake: a requester raises req[i] and holds it for its whole burst;
    // it may drive accesses in every cycle grant[i] is seen high, and releases
    // ownership by dropping req[i]. A grant is never taken away while req[i]
    // stays high, and only one grant bit is ever high.

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_owner_q, last_owner_d;
    logic [CNT_W-1:0] hold_count_q, hold_count_d;
    logic             hold_violation_q, hold_violation_d;

    logic [IDX_W-1:0]   pick_start;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic [NUM_REQ-1:0] owner_onehot;
    logic               owner_req;
    logic               others_pending;

    always_comb begin
        owner_onehot          = '0;
        owner_onehot[owner_q] = 1'b1;
    end

    assign owner_req      = req[owner_q];
    assign others_pending = |(req & ~owner_onehot);

    // Idle scans after the last releaser; a handoff scans after the current owner.
    assign pick_start = (state_q == ST_OWNED) ? IDX_W'(rr_next(int'(owner_q), NUM_REQ))
                                              : IDX_W'(rr_next(int'(last_owner_q), NUM_REQ));

    scratch_mem_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req   (req),
        .start (pick_start),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        last_owner_d     = last_owner_q;
        hold_count_d     = hold_count_q;
        hold_violation_d = hold_violation_q;
        if (!testMuxSel) begin
            case (state_q)
                ST_IDLE: begin
                    hold_count_d = '0;
                    if (pick_valid) begin
                        state_d = ST_OWNED;
                        owner_d = pick_idx;
                    end
                end
                ST_OWNED: begin
                    if (hold_count_q == CNT_MAX && others_pending) begin
                        hold_violation_d = 1'b1;
                    end
                    if (owner_req) begin
                        if (hold_count_q != CNT_MAX) begin
                            hold_count_d = hold_count_q + 1'b1;
                        end
                    end else begin
                        last_owner_d = owner_q;
                        hold_count_d = '0;
                        if (pick_valid) begin
                            owner_d = pick_idx;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d      = ST_IDLE;
                    hold_count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            owner_q          <= '0;
            last_owner_q     <= IDX_W'(NUM_REQ - 1);
            hold_count_q     <= '0;
            hold_violation_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            owner_q          <= owner_d;
            last_owner_q     <= last_owner_d;
            hold_count_q     <= hold_count_d;
            hold_violation_q <= hold_violation_d;
        end
    end

    assign grant = (state_q == ST_OWNED && !testMuxSel) ? owner_onehot : '0;

    // The owner's write is gated by its own req so a releasing owner writes nothing.
    always_comb begin
        memAddr = '0;
        memWE   = 1'b0;
        memOut  = '0;
        if (testMuxSel) begin
            memAddr = testMemWrite ? testWriteAddr : testReadAddr;
            memWE   = testMemWrite;
            memOut  = testMemOut;
        end else if (state_q == ST_OWNED) begin
            memAddr = reqAddr[owner_q*SCRATCH_ADDR_W +: SCRATCH_ADDR_W];
            memWE   = reqWE[owner_q] & owner_req;
            memOut  = reqData[owner_q*SCRATCH_DATA_W +: SCRATCH_DATA_W];
        end
    end

    assign holdViolation = hold_violation_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_scratch_mem_arbiter.sv
// Bench for scratch_mem_arbiter: a table of per-cycle vectors with expected
// owner/outputs checked through an expected queue, then random invariant checks.
module tb_scratch_mem_arbiter;
    import scratch_mem_arbiter_pkg::*;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;
    localparam int EXP_W    = 4 + 1 + 11 + 32 + 1;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] we;
        logic       tsel;
        logic       twe;
        int         own;
        logic       hv;
    } vec_t;

    logic                         clk;
    logic                         reset;
    logic [N-1:0]                 req;
    logic [N-1:0]                 reqWE;
    logic [N*SCRATCH_ADDR_W-1:0]  reqAddr;
    logic [N*SCRATCH_DATA_W-1:0]  reqData;
    logic [N-1:0]                 grant;
    logic                         testMuxSel;
    logic                         testMemWrite;
    logic [SCRATCH_ADDR_W-1:0]    testWriteAddr;
    logic [SCRATCH_ADDR_W-1:0]    testReadAddr;
    logic [SCRATCH_DATA_W-1:0]    testMemOut;
    logic [SCRATCH_ADDR_W-1:0]    memAddr;
    logic                         memWE;
    logic [SCRATCH_DATA_W-1:0]    memOut;
    logic                         holdViolation;
    arb_state_e                   dbg_state;

    vec_t             vecs[$];
    logic [EXP_W-1:0] exp_q[$];
    int               n_checks = 0;
    int               n_fail   = 0;

    scratch_mem_arbiter #(
        .NUM_REQ  (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .reqWE         (reqWE),
        .reqAddr       (reqAddr),
        .reqData       (reqData),
        .grant         (grant),
        .testMuxSel    (testMuxSel),
        .testMemWrite  (testMemWrite),
        .testWriteAddr (testWriteAddr),
        .testReadAddr  (testReadAddr),
        .testMemOut    (testMemOut),
        .memAddr       (memAddr),
        .memWE         (memWE),
        .memOut        (memOut),
        .holdViolation (holdViolation),
        .dbg_state     (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] addr_of(input int i);
        return 11'h120 + 11'(i) * 11'h111;
    endfunction

    function automatic logic [31:0] data_of(input int i);
        return 32'h0000_1234 + 32'(i) * 32'h1111_0000;
    endfunction

    task automatic add(input logic rst, input logic [3:0] r, input logic [3:0] w,
                       input logic ts, input logic tw, input int own, input logic hv);
        vec_t v;
        v.rst = rst; v.req = r; v.we = w; v.tsel = ts; v.twe = tw; v.own = own; v.hv = hv;
        vecs.push_back(v);
    endtask

    // Expected outputs for a vector, given the owner the arbiter should hold.
    function automatic logic [EXP_W-1:0] model(input vec_t v);
        logic [3:0]  g;
        logic        w;
        logic [10:0] a;
        logic [31:0] d;
        logic [1:0]  oi;
        g = '0; w = 1'b0; a = '0; d = '0; oi = '0;
        if (v.tsel) begin
            w = v.twe;
            a = v.twe ? 11'h7FF : 11'h055;
            d = 32'h0000_DEAD;
        end else if (v.own >= 0) begin
            oi = 2'(v.own);
            g  = 4'b0001 << oi;
            w  = v.we[oi] & v.req[oi];
            a  = addr_of(v.own);
            d  = data_of(v.own);
        end
        return {g, w, a, d, v.hv};
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
        end
    endtask

    // Driver
    task automatic drive(input vec_t v);
        reset        = v.rst;
        req          = v.req;
        reqWE        = v.we;
        testMuxSel   = v.tsel;
        testMemWrite = v.twe;
    endtask

    // Scoreboard pop and compare
    task automatic check_row(input int row);
        logic [EXP_W-1:0] e;
        if (exp_q.size() == 0) begin
            chk("exp_q_empty", row, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("grant",         row, 32'(grant),         32'(e[48:45]));
            chk("memWE",         row, 32'(memWE),         32'(e[44]));
            chk("memAddr",       row, 32'(memAddr),       32'(e[43:33]));
            chk("memOut",        row, memOut,             e[32:1]);
            chk("holdViolation", row, 32'(holdViolation), 32'(e[0]));
        end
    endtask

    task automatic build_table();
        // reset state, then single requester write
        add(1, 4'b0000, 4'b0000, 0, 0, -1, 0);
        add(0, 4'b0001, 4'b0001, 0, 0, -1, 0);
        add(0, 4'b0001, 4'b0001, 0, 0,  0, 0);
        add(0, 4'b0001, 4'b0000, 0, 0,  0, 0);
        add(0, 4'b0000, 4'b0000, 0, 0,  0, 0);
        add(1, 4'b0000, 4'b0000, 0, 0, -1, 0);
        // all requesting: each owner holds 3 cycles, drops one cycle, re-requests
        add(0, 4'b1111, 4'b1111, 0, 0, -1, 0);
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 3; c++) add(0, 4'b1111, 4'b1111, 0, 0, k, 0);
            add(0, 4'b1111 & ~(4'b0001 << k), 4'b1111, 0, 0, k, 0);
        end
        add(0, 4'b1111, 4'b1111, 0, 0,  0, 0);
        add(0, 4'b0000, 4'b1111, 0, 0,  0, 0);
        add(0, 4'b0000, 4'b1111, 0, 0, -1, 0);
        // test port override during owner 2's burst
        add(0, 4'b0100, 4'b0100, 0, 0, -1, 0);
        add(0, 4'b0100, 4'b0100, 0, 0,  2, 0);
        add(0, 4'b0100, 4'b0100, 1, 1,  2, 0);
        add(0, 4'b0100, 4'b0100, 1, 0,  2, 0);
        add(0, 4'b0110, 4'b0110, 1, 0,  2, 0);
        add(0, 4'b0110, 4'b0110, 0, 0,  2, 0);
        add(0, 4'b0010, 4'b0110, 0, 0,  2, 0);
        add(0, 4'b0010, 4'b0110, 0, 0,  1, 0);
        add(0, 4'b0000, 4'b0000, 0, 0,  1, 0);
        add(0, 4'b0000, 4'b0000, 0, 0, -1, 0);
        // requester 1 holds 10 cycles while requester 3 waits
        add(0, 4'b0010, 4'b0000, 0, 0, -1, 0);
        for (int c = 0; c < 9; c++) add(0, 4'b1010, 4'b0000, 0, 0, 1, 0);
        add(0, 4'b1010, 4'b0000, 0, 0,  1, 1);
        add(0, 4'b1000, 4'b0000, 0, 0,  1, 1);
        add(0, 4'b1000, 4'b0000, 0, 0,  3, 1);
        add(0, 4'b0000, 4'b0000, 0, 0,  3, 1);
        add(0, 4'b0000, 4'b0000, 0, 0, -1, 1);
        // reset in the middle of requester 0's write burst
        add(0, 4'b0001, 4'b0001, 0, 0, -1, 1);
        add(0, 4'b0001, 4'b0001, 0, 0,  0, 1);
        add(1, 4'b0001, 4'b0001, 0, 0,  0, 1);
        add(0, 4'b1001, 4'b1001, 0, 0, -1, 0);
        add(0, 4'b1001, 4'b1001, 0, 0,  0, 0);
        add(0, 4'b1000, 4'b1001, 0, 0,  0, 0);
        add(0, 4'b1000, 4'b1001, 0, 0,  3, 0);
        add(0, 4'b0000, 4'b0000, 0, 0,  3, 0);
        add(0, 4'b0000, 4'b0000, 0, 0, -1, 0);
    endtask

    initial begin
        logic [N-1:0] prev_req;
        reset         = 1'b1;
        req           = '0;
        reqWE         = '0;
        testMuxSel    = 1'b0;
        testMemWrite  = 1'b0;
        testWriteAddr = 11'h7FF;
        testReadAddr  = 11'h055;
        testMemOut    = 32'h0000_DEAD;
        for (int i = 0; i < N; i++) begin
            reqAddr[i*SCRATCH_ADDR_W +: SCRATCH_ADDR_W] = addr_of(i);
            reqData[i*SCRATCH_DATA_W +: SCRATCH_DATA_W] = data_of(i);
        end
        build_table();
        repeat (2) @(posedge clk);

        for (int r = 0; r < vecs.size(); r++) begin
            @(posedge clk);
            #1;
            drive(vecs[r]);
            exp_q.push_back(model(vecs[r]));
            @(negedge clk);
            check_row(r);
        end

        // Random traffic: grant must follow last edge's requests, stay one-hot,
        // and the write enable must come only from a still-requesting grantee.
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            prev_req = req;
            req      = 4'($urandom_range(0, 15));
            reqWE    = 4'($urandom_range(0, 15));
            @(negedge clk);
            chk("rand_onehot",    c, 32'($onehot0(grant)),  32'd1);
            chk("rand_grant_req", c, 32'(grant & ~prev_req), 32'd0);
            chk("rand_busy",      c, 32'(grant != '0),       32'(prev_req != '0));
            chk("rand_memWE",     c, 32'(memWE),             32'(|(grant & req & reqWE)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
